// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: shared state encoding and width defaults for the load unit
package mem_load_unit_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: request, memory and response signals of the load unit (MEM_LOAD_BYTE_EN adds req_byte)
interface mem_load_unit_if import mem_load_unit_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
`ifdef MEM_LOAD_BYTE_EN
  logic              req_byte;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  modport slave (
`ifdef MEM_LOAD_BYTE_EN
    input req_byte,
`endif
    input req_valid, req_addr, mem_rdata, rsp_ready,
    output req_ready, mem_addr, mem_rd, rsp_valid, rsp_data, busy
  );
  modport master (
`ifdef MEM_LOAD_BYTE_EN
    output req_byte,
`endif
    output req_valid, req_addr, mem_rdata, rsp_ready,
    input req_ready, mem_addr, mem_rd, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/mem_load_unit_latency_counter.sv
// latency_counter: loadable down-counter that saturates at zero and flags it
module latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: single-outstanding load with fixed read latency and valid/ready response
// MEM_LOAD_BYTE_EN adds sign-extended byte loads selected by the request address LSB.
module mem_load_unit import mem_load_unit_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int READ_LATENCY = 2,
  parameter int CNT_W        = 4
) (
  input logic           clk,
  input logic           reset,
  mem_load_unit_if.slave bus
);
  if (READ_LATENCY < 1 || READ_LATENCY > 2**CNT_W) begin : g_bad_latency
    $error("READ_LATENCY %0d outside 1..2**CNT_W", READ_LATENCY);
  end
  state_t            state_q, state_d;
  logic              req_ready, accept, capture, dec, zero;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mem_addr_q, next_addr;
  logic              mem_rd_q, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q, cap_data;
  latency_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .reset(reset), .load(accept), .dec(dec),
    .load_val(CNT_W'(READ_LATENCY - 1)), .cnt(cnt), .zero(zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? WAIT : IDLE;
      WAIT:    state_d = zero ? DONE : WAIT;
      DONE:    state_d = bus.rsp_ready ? (bus.req_valid ? WAIT : IDLE) : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state_q == IDLE || (state_q == DONE && bus.rsp_ready);
    accept    = bus.req_valid && req_ready;
    capture   = state_q == WAIT && zero;
    dec       = state_q == WAIT && !zero;
  end
`ifdef MEM_LOAD_BYTE_EN
  logic       byte_q, lsb_q;
  logic [7:0] byte_sel;
  always_comb begin
    byte_sel  = lsb_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    cap_data  = byte_q ? {{(DATA_W-8){byte_sel[7]}}, byte_sel} : bus.mem_rdata;
    next_addr = bus.req_byte ? {bus.req_addr[ADDR_W-1:1], 1'b0} : bus.req_addr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      byte_q <= 1'b0;
      lsb_q  <= 1'b0;
    end else if (accept) begin
      byte_q <= bus.req_byte;
      lsb_q  <= bus.req_addr[0];
    end
`else
  always_comb begin
    cap_data  = bus.mem_rdata;
    next_addr = bus.req_addr;
  end
`endif
  // a back-to-back accept leaves DONE with rsp_ready high, so the same clear covers it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      mem_rd_q <= accept;
      if (accept) mem_addr_q <= next_addr;
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= cap_data;
      end else if (state_q == DONE && bus.rsp_ready) rsp_valid_q <= 1'b0;
    end
  assign bus.req_ready = req_ready;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = state_q != IDLE;
endmodule
